mdu_sequencer: RTL
==================

# mdu_sequencer

Sequences the shared iterative multiply/divide unit for the M-extension path of the 5-stage RV32IM pipeline. Sits beside the execute stage. Accepts the decoder's `start` and 5-bit `alu_op` (MUL..REMU), launches the iterative unit, and stalls the pipeline until the result is ready. Resolves RISC-V divide corner cases (divide-by-zero, signed overflow) directly, without launching the unit. Includes a watchdog and flush/abort handling.

## Interface
- `TIMEOUT`, 40: maximum RUN cycles to wait for `unit_done` before forcing completion.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  M-ext instruction present in execute (decoder start).
- `alu_op`  in  5  op code: MUL=01011, MULH=01100, MULHSU=01101, MULHU=01110, DIV=01111, DIVU=10000, REM=10001, REMU=10010.
- `rs1_val`, `rs2_val`  in  32 each  operands.
- `flush`  in  1  pipeline flush of the execute stage.
- `unit_start`  out  1  one-cycle launch pulse to the iterative unit.
- `unit_op`  out  3  funct3 equivalent (`alu_op` − 01011), registered at launch.
- `unit_a`, `unit_b`  out  32 each  operands, registered at launch.
- `unit_abort`  out  1  one-cycle pulse that cancels the iterative unit.
- `unit_done`  in  1  iterative unit completion strobe.
- `unit_result`  in  32  unit result, valid with `unit_done`.
- `stall`  out  1  freeze IF/ID/EX.
- `result`  out  32  writeback value.
- `result_valid`  out  1  `result` valid (one cycle).
- `err`  out  1  watchdog expiry, one cycle, coincident with `result_valid`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SHORT, RUN, DONE.
- IDLE, `start`=1, `flush`=0, `alu_op` in the M range:
  - Corner case goes to SHORT:
    - DIV/DIVU with `rs2_val`=0 → result 0xFFFFFFFF.
    - REM/REMU with `rs2_val`=0 → result `rs1_val`.
    - DIV with `rs1_val`=0x80000000 and `rs2_val`=0xFFFFFFFF → result 0x80000000.
    - REM with the same operands → result 0.
  - All other cases go to RUN. Operands and `unit_op` are latched on entry.
- `alu_op` outside the M range: ignored, stay IDLE.
- SHORT → DONE unconditionally. The precomputed result is latched.
- RUN:
  - `unit_start`=1 in the first RUN cycle only.
  - Cycle counter cleared on entry, increments each RUN cycle.
  - `unit_done`=1 → latch `unit_result` → DONE. `unit_done` in the same cycle as `unit_start` is legal.
  - Counter reaching `TIMEOUT`−1 without `unit_done` → `result`=0, set `err` flag → DONE.
- DONE: `result_valid`=1, `err` per flag, `stall`=0 → IDLE. `start` is ignored in DONE because the instruction is leaving execute.
- `flush`=1 in SHORT/RUN/DONE: next state IDLE, no `result_valid`. `unit_abort` pulses next cycle if flushed in RUN.
- `flush`=1 in IDLE: no launch.
- `flush` has priority over `unit_done` and timeout.
- `stall` = (IDLE & `start` & valid op & ~`flush`) | SHORT | RUN. Combinational.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: state IDLE, all outputs 0, `result`=0, counter 0, `err` flag 0. Reset mid-RUN abandons the operation. No `unit_abort` is generated; the unit is reset by the same `rst`.
- Corner case: `start` at cycle 0 → SHORT at 1 → `result_valid` at 2. `stall` is high in cycles 0–1.
- Normal: `start` at cycle 0 → `unit_start` at 1. `unit_done` at cycle N → `result_valid` at N+1. `stall` is high from cycle 0 through N.
- Timeout: `result_valid`=`err`=1 at cycle `TIMEOUT`+1 after `start`.
- Back-to-back: the next `start` is accepted in the cycle after DONE, at the earliest.
- `result` holds its value until the next latch. Only `result_valid` qualifies it.

## Test plan
- MUL 7×6: `start` cycle 0, `unit_done` with 42 at cycle 33 → `unit_start` at 1 only, `stall` 0..33, `result_valid`=1 with 42 at 34, `stall`=0 at 34.
- DIVU 100/0 and REM 0x80000000 % 0xFFFFFFFF → no `unit_start`, `result_valid` at cycle 2 with 0xFFFFFFFF and 0 respectively, `stall` high cycles 0–1.
- DIV with `unit_done` never asserted, `TIMEOUT`=40 → `result_valid`=`err`=1 with `result`=0 at cycle 41, then IDLE.
- `flush` at cycle 10 of RUN → `unit_abort` at 11, `busy`=0 at 11, no `result_valid`. `flush` colliding with `unit_done` → still no `result_valid`.
- Two back-to-back MULH ops with `start` held high through DONE → exactly two `unit_start` pulses and two `result_valid` pulses, separated by one IDLE cycle.
- `rst` asserted asynchronously mid-RUN → all outputs 0 immediately. A new `start` after release is accepted normally.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: launch, stall and writeback control for the shared
// iterative multiply/divide unit; divide corner cases resolve locally.
module mdu_sequencer #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  alu_op,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic        flush,
   output logic        unit_start,
   output logic [2:0]  unit_op,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_abort,
   input  logic        unit_done,
   input  logic [31:0] unit_result,
   output logic        stall,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        err,
   output logic        busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   localparam logic [4:0] OP_MUL  = 5'b01011;
   localparam logic [4:0] OP_REMU = 5'b10010;

   localparam logic [2:0] F_DIV  = 3'd4;
   localparam logic [2:0] F_DIVU = 3'd5;
   localparam logic [2:0] F_REM  = 3'd6;
   localparam logic [2:0] F_REMU = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      SHORT,
      RUN,
      DONE
   } state_t;

   state_t state, state_n;

   logic [CW-1:0] cnt;
   logic          first;
   logic          err_q;
   logic          abort_q;
   logic [31:0]   short_q;

   logic        valid_op;
   logic [2:0]  f3;
   logic        div0;
   logic        ovf;
   logic        corner;
   logic [31:0] short_val;

   logic accept;
   logic go_run;
   logic go_short;
   logic take_short;
   logic take_unit;
   logic time_out;
   logic do_abort;

   // Low three bits of (alu_op - MUL) equal alu_op[2:0] - 3 modulo 8.
   always_comb begin
      f3        = alu_op[2:0] - 3'd3;
      valid_op  = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
      div0      = (rs2_val == 32'h0);
      ovf       = (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
      corner    = 1'b0;
      short_val = 32'h0;
      case (f3)
         F_DIV: begin
            corner    = div0 | ovf;
            short_val = div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
         end
         F_DIVU: begin
            corner    = div0;
            short_val = 32'hFFFF_FFFF;
         end
         F_REM: begin
            corner    = div0 | ovf;
            short_val = div0 ? rs1_val : 32'h0;
         end
         F_REMU: begin
            corner    = div0;
            short_val = rs1_val;
         end
         default: begin
            corner    = 1'b0;
            short_val = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      go_run     = 1'b0;
      go_short   = 1'b0;
      take_short = 1'b0;
      take_unit  = 1'b0;
      time_out   = 1'b0;
      do_abort   = 1'b0;
      accept     = start & valid_op & ~flush;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (corner) begin
                  go_short = 1'b1;
                  state_n  = SHORT;
               end else begin
                  go_run  = 1'b1;
                  state_n = RUN;
               end
            end
         end
         SHORT: begin
            if (flush) begin
               state_n = IDLE;
            end else begin
               take_short = 1'b1;
               state_n    = DONE;
            end
         end
         RUN: begin
            // Flush wins over completion and over the watchdog.
            if (flush) begin
               do_abort = 1'b1;
               state_n  = IDLE;
            end else if (unit_done) begin
               take_unit = 1'b1;
               state_n   = DONE;
            end else if (cnt == LAST) begin
               time_out = 1'b1;
               state_n  = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      stall        = ((state == IDLE) & accept)
                   | (state == SHORT)
                   | (state == RUN);
      unit_start   = (state == RUN) & first;
      result_valid = (state == DONE) & ~flush;
      err          = result_valid & err_q;
      unit_abort   = abort_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         first   <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         short_q <= 32'h0;
         result  <= 32'h0;
         unit_op <= 3'd0;
         unit_a  <= 32'h0;
         unit_b  <= 32'h0;
      end else begin
         abort_q <= do_abort;
         first   <= go_run;
         if (go_run) begin
            unit_op <= f3;
            unit_a  <= rs1_val;
            unit_b  <= rs2_val;
            cnt     <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
         end
         if (go_short) begin
            short_q <= short_val;
         end
         if (take_short) begin
            result <= short_q;
            err_q  <= 1'b0;
         end
         if (take_unit) begin
            result <= unit_result;
            err_q  <= 1'b0;
         end
         if (time_out) begin
            result <= 32'h0;
            err_q  <= 1'b1;
         end
      end
   end

endmodule
